// File: rtl/bus_scheduler.sv
// Round-robin grant of one of three masters to the MAC/FFT slave, held until ack; grant and select are registered (1 cycle after req).
// Backpressure: a granted transfer stalls until ack, REL then adds one dead cycle; watchdog abort built only with SCHED_TIMEOUT_EN.
module bus_scheduler #(
   parameter int NM      = 3,
   parameter int TIMEOUT = 15
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [NM-1:0] req,
   input  logic [NM-1:0] slave_id,
   input  logic          ack,
   output logic [NM-1:0] gnt,
   output logic [1:0]    sel,
   output logic          busy,
   output logic          err
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_REL  = 2'd2
   } state_t;

   if (NM != 3 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_cfg
      $error("bus_scheduler: NM must be 3 and TIMEOUT must be 1..255");
   end

   state_t        state_q, state_d;
   logic [1:0]    ptr_q, ptr_d;
   logic [NM-1:0] gnt_q, gnt_d;
   logic [1:0]    sel_q, sel_d;
   logic          pick_vld;
   logic [1:0]    pick_idx;
   logic [2:0]    cand;
   logic          tmo;

   // Scan downward so the candidate closest to ptr is the one left standing.
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = 2'd0;
      cand     = 3'd0;
      for (int j = NM - 1; j >= 0; j--) begin
         cand = {1'b0, ptr_q} + 3'(j);
         if (cand >= 3'd3) begin
            cand = cand - 3'd3;
         end
         if (req[cand[1:0]]) begin
            pick_vld = 1'b1;
            pick_idx = cand[1:0];
         end
      end
   end

`ifdef SCHED_TIMEOUT_EN
   logic [7:0] cnt_q;
   logic       err_q;

   // cnt_q holds the number of completed BUSY cycles; abort on the TIMEOUT-th.
   assign tmo = (state_q == S_BUSY) && (cnt_q == 8'(TIMEOUT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= 8'd0;
         err_q <= 1'b0;
      end else begin
         err_q <= tmo && !ack;
         if (state_q != S_BUSY || ack || tmo) begin
            cnt_q <= 8'd0;
         end else begin
            cnt_q <= cnt_q + 8'd1;
         end
      end
   end

   assign err = err_q;
`else
   assign tmo = 1'b0;
   assign err = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         ptr_q   <= 2'd0;
         gnt_q   <= '0;
         sel_q   <= 2'b00;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gnt_q   <= gnt_d;
         sel_q   <= sel_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (pick_vld) state_d = S_BUSY;
         S_BUSY:  if (ack || tmo) state_d = S_REL;
         S_REL:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      gnt_d = '0;
      sel_d = 2'b00;
      ptr_d = ptr_q;
      case (state_q)
         S_IDLE: begin
            if (pick_vld) begin
               gnt_d = {{(NM-1){1'b0}}, 1'b1} << pick_idx;
               sel_d = slave_id[pick_idx] ? 2'b10 : 2'b01;
               ptr_d = (pick_idx == 2'd2) ? 2'd0 : pick_idx + 2'd1;
            end
         end
         S_BUSY: begin
            if (!(ack || tmo)) begin
               gnt_d = gnt_q;
               sel_d = sel_q;
            end
         end
         default: begin
            gnt_d = '0;
            sel_d = 2'b00;
         end
      endcase
   end

   assign gnt  = gnt_q;
   assign sel  = sel_q;
   assign busy = (state_q == S_BUSY);

endmodule

// File: tb/tb_bus_scheduler.sv
// Directed-vector bench for bus_scheduler; timeout checks follow SCHED_TIMEOUT_EN.
module tb_bus_scheduler;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] req = 3'b000;
   logic [2:0] slave_id = 3'b000;
   logic       ack = 1'b0;
   logic [2:0] gnt;
   logic [1:0] sel;
   logic       busy;
   logic       err;

   int n_vec = 0;
   int n_err = 0;

   bus_scheduler #(.NM(3), .TIMEOUT(15)) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .slave_id (slave_id),
      .ack      (ack),
      .gnt      (gnt),
      .sel      (sel),
      .busy     (busy),
      .err      (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Inputs change and outputs are sampled on the falling edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic release_bus();
      ack = 1'b1;
      step();
      chk("rel_gnt", gnt, 3'b000);
      ack = 1'b0;
      step();
   endtask

   logic [2:0] rr_exp [4] = '{3'b001, 3'b010, 3'b100, 3'b001};

   initial begin
      #1;
      chk("rst_gnt", gnt, 3'b000);
      chk("rst_sel", sel, 2'b00);
      chk("rst_busy", busy, 1'b0);
      chk("rst_err", err, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      // Single grant to master 0, MAC slave.
      req = 3'b001;
      slave_id = 3'b000;
      step();
      chk("t1_gnt", gnt, 3'b001);
      chk("t1_sel", sel, 2'b01);
      chk("t1_busy", busy, 1'b1);
      req = 3'b000;
      ack = 1'b1;
      step();
      chk("t1_gnt_off", gnt, 3'b000);
      chk("t1_busy_rel", busy, 1'b0);
      ack = 1'b0;
      step();
      chk("t1_busy_idle", busy, 1'b0);

      // Round robin with all masters requesting, from a fresh pointer.
      rst = 1'b1;
      #1 rst = 1'b0;
      req = 3'b111;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("rr_gnt", gnt, rr_exp[i]);
         ack = 1'b1;
         step();
         chk("rr_gap1", gnt, 3'b000);
         ack = 1'b0;
         step();
         chk("rr_gap2", gnt, 3'b000);
      end
      req = 3'b000;

      // Slave select follows the winner's slave_id bit.
      req = 3'b110;
      slave_id = 3'b100;
      step();
      chk("sid_gnt1", gnt, 3'b010);
      chk("sid_sel1", sel, 2'b01);
      release_bus();
      step();
      chk("sid_gnt2", gnt, 3'b100);
      chk("sid_sel2", sel, 2'b10);
      req = 3'b000;
      release_bus();

      // Grant is frozen against req/slave_id changes while busy.
      req = 3'b001;
      slave_id = 3'b000;
      step();
      chk("frz_gnt0", gnt, 3'b001);
      req = 3'b000;
      slave_id = 3'b001;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("frz_gnt", gnt, 3'b001);
         chk("frz_sel", sel, 2'b01);
      end
      slave_id = 3'b000;
      release_bus();

`ifdef SCHED_TIMEOUT_EN
      req = 3'b001;
      step();
      req = 3'b000;
      for (int i = 1; i < 15; i++) begin
         step();
         chk("tmo_hold", gnt, 3'b001);
         chk("tmo_noerr", err, 1'b0);
      end
      step();
      chk("tmo_gnt", gnt, 3'b000);
      chk("tmo_err", err, 1'b1);
      step();
      chk("tmo_err_clr", err, 1'b0);
      req = 3'b001;
      step();
      req = 3'b000;
      for (int i = 1; i < 15; i++) step();
      ack = 1'b1;
      step();
      chk("tmo_ack_gnt", gnt, 3'b000);
      chk("tmo_ack_err", err, 1'b0);
      ack = 1'b0;
      step();
      chk("tmo_ack_err2", err, 1'b0);
`else
      req = 3'b001;
      step();
      req = 3'b000;
      for (int i = 0; i < 100; i++) begin
         step();
         chk("wait_gnt", gnt, 3'b001);
         chk("wait_err", err, 1'b0);
      end
      release_bus();
`endif

      // Asynchronous reset while master 2 holds the bus.
      req = 3'b100;
      step();
      chk("ar_gnt2", gnt, 3'b100);
      req = 3'b000;
      #2 rst = 1'b1;
      #1;
      chk("ar_gnt", gnt, 3'b000);
      chk("ar_sel", sel, 2'b00);
      chk("ar_busy", busy, 1'b0);
      chk("ar_err", err, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      req = 3'b111;
      step();
      chk("ar_restart", gnt, 3'b001);
      req = 3'b000;
      release_bus();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/bus_scheduler.md
# bus_scheduler

Round-robin bus scheduler for the shared master/slave data bus. It arbitrates among three masters and holds the winner's grant until the addressed slave acknowledges. It drives a one-hot select to the MAC slave (slave 0) or the FFT slave (slave 1), taken from the winner's `slave_id` bit. It sits between the master request lines and the slave `sel` inputs. An optional watchdog aborts transfers whose slave never acknowledges.

## Interface
- `NM`, 3: number of masters. Fixed at 3; other values are unsupported.
- `TIMEOUT`, 15: cycles in BUSY without ack before abort (watchdog builds only). Legal range is 1..255.
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req` in 3: per-master request. Bit i is master i.
- `slave_id` in 3: per-master target. Bit i is 0 for slave 0 (MAC) and 1 for slave 1 (FFT).
- `ack` in 1: OR of slave acks, sampled on the clock edge.
- `gnt` out 3: one-hot grant, registered.
- `sel` out 2: one-hot slave select, registered. 2'b01 selects slave 0; 2'b10 selects slave 1.
- `busy` out 1: high in the BUSY state.
- `err` out 1: one-cycle timeout pulse. Tied to 0 when the watchdog is not built.

## Operation
- FSM states:
  - IDLE: no grant.
  - BUSY: grant held.
  - REL: one release cycle.
- Reset (asynchronous, immediate):
  - `gnt`=0, `sel`=0, `busy`=0, `err`=0.
  - State goes to IDLE; round-robin pointer `ptr`=0; timeout counter=0.
- IDLE:
  - If `req` != 0, pick the first set bit scanning from `ptr` upward, modulo 3. Call it k.
  - Register `gnt`=1<<k and `sel` from `slave_id[k]`, and go to BUSY.
  - `ptr` becomes (k+1) mod 3.
  - If `req` == 0, stay in IDLE.
- BUSY:
  - `gnt` and `sel` are frozen. `req` and `slave_id` changes are ignored.
  - `ack`=1: clear `gnt`/`sel` and go to REL.
  - Watchdog builds only: count BUSY cycles. When the count reaches `TIMEOUT` with `ack`=0, clear `gnt`/`sel`, pulse `err` for one cycle, and go to REL.
  - `ack` and timeout in the same cycle: ack wins and `err` stays 0.
- REL: outputs are all zero. Unconditionally go to IDLE; no arbitration happens in REL.
- A master that drops `req` while granted keeps its grant until ack or timeout.
- `ack` seen in IDLE or REL is ignored.
- Exactly one `gnt` bit is ever high. `sel` is nonzero iff `gnt` is nonzero.

## Timing
- `req` high at edge N (state IDLE): `gnt`/`sel`/`busy` are high after edge N.
- `ack` high at edge M: `gnt`/`sel`/`busy` are low after edge M. State is REL during M..M+1 and IDLE after M+1.
- Earliest next grant is at edge M+2, so grants are separated by 2 idle cycles minimum.
- Timeout: first BUSY cycle after grant edge N counts as 1.
  - At edge N+`TIMEOUT` with no ack, `gnt` drops and `err`=1 for the cycle N+`TIMEOUT`..N+`TIMEOUT`+1.
- Counter width is 8 bits. It clears on entering BUSY and never wraps, because abort happens at `TIMEOUT` ≤ 255.
- Reset asserted mid-BUSY: outputs go to 0 asynchronously. After release, arbitration restarts from master 0.

## Configuration
- `SCHED_TIMEOUT_EN` defined:
  - Watchdog counter and `err` logic are built.
  - BUSY aborts after `TIMEOUT` cycles as described above.
- Not defined:
  - No counter is built and `err` is constant 0.
  - BUSY waits for `ack` indefinitely; `TIMEOUT` is unused.

## Test plan
- Reset, then `req`=3'b001, `slave_id`=3'b000:
  - `gnt`=001 and `sel`=01 one edge later.
  - `ack` pulse gives `gnt`=000 next edge.
  - `busy` is 0 for 2 cycles afterward.
- `req`=3'b111 held; each grant is acked one cycle after it appears:
  - Grant order is 001, 010, 100, 001.
  - Each grant is separated by 2 zero-grant cycles.
- `req`=3'b110, `slave_id`=3'b100:
  - Master 1 granted first with `sel`=01.
  - Then master 2 with `sel`=10.
- Grant master 0, toggle `slave_id[0]` and drop `req[0]` during BUSY:
  - `gnt`=001 and `sel`=01 are unchanged until `ack`.
- With `SCHED_TIMEOUT_EN`, `TIMEOUT`=15, grant with `ack` held 0:
  - `gnt` drops and `err`=1 for exactly one cycle, 15 edges after the grant edge.
  - `ack`=1 on that same edge: no `err`.
  - Without the macro: `gnt` stays high for 100 cycles and `err` stays 0.
- Assert `rst` mid-BUSY with master 2 granted:
  - All outputs are 0 immediately.
  - After release, `req`=3'b111 grants master 0 first.
